// File: rtl/cpu8_pkg.sv
// cpu8_pkg: shared definitions for the cpu8 accumulator core.
//   - Opcode constants (8-bit).
//   - Flag bit indices within the 4-bit architectural flag register.
//   - Sequencer state enum.
//   - Decode helpers used by the core.
package cpu8_pkg;

  localparam logic [7:0] OpNop = 8'h00;
  localparam logic [7:0] OpHlt = 8'h02;
  localparam logic [7:0] OpLda = 8'hA9;
  localparam logic [7:0] OpLdx = 8'hA2;
  localparam logic [7:0] OpLdy = 8'hA0;
  localparam logic [7:0] OpAdd = 8'h69;
  localparam logic [7:0] OpSub = 8'hE9;
  localparam logic [7:0] OpAnd = 8'h29;
  localparam logic [7:0] OpOr  = 8'h09;
  localparam logic [7:0] OpXor = 8'h49;
  localparam logic [7:0] OpNot = 8'hB6;
  localparam logic [7:0] OpInc = 8'hE8;
  localparam logic [7:0] OpDec = 8'hCA;
  localparam logic [7:0] OpBeq = 8'hF0;
  localparam logic [7:0] OpBne = 8'hD0;
  localparam logic [7:0] OpBra = 8'h80;
  localparam logic [7:0] OpSta = 8'h8D;

  localparam int unsigned FlagC = 0;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagV = 3;

  typedef enum logic [2:0] {
    StFetch,
    StExec,
    StHalted,
    StAdrl,
    StAdrh,
    StStore
  } cpu8_state_e;

  // Opcodes that carry a one-byte operand (immediates and branch offsets).
  function automatic logic is_imm(input logic [7:0] op);
    case (op)
      OpLda, OpLdx, OpLdy, OpAdd, OpSub, OpAnd, OpOr, OpXor,
      OpBeq, OpBne, OpBra: is_imm = 1'b1;
      default:             is_imm = 1'b0;
    endcase
  endfunction

  function automatic logic is_branch(input logic [7:0] op);
    is_branch = (op == OpBeq) || (op == OpBne) || (op == OpBra);
  endfunction

  // Opcodes whose ALU result lands in the accumulator.
  function automatic logic writes_acc(input logic [7:0] op);
    case (op)
      OpLda, OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNot, OpInc, OpDec: writes_acc = 1'b1;
      default:                                                      writes_acc = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu8_alu.sv
// cpu8_alu: combinational ALU for the cpu8 core.
// Ports:
//   op        in  8  opcode being executed
//   a         in  8  accumulator
//   b         in  8  operand byte (immediate)
//   flags_in  in  4  current flags {V,N,Z,C}
//   result    out 8  computed value (a when the opcode does not produce one)
//   flags_out out 4  next flags (flags_in for opcodes that leave flags alone)
module cpu8_alu
  import cpu8_pkg::*;
(
  input  logic [7:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] flags_in,
  output logic [7:0] result,
  output logic [3:0] flags_out
);

  logic [7:0] b_eff;
  logic       cin;
  logic [8:0] sum;
  logic       zn_upd;

  // SUB reuses the adder as a + ~b + 1, so carry-out means "no borrow".
  assign b_eff = (op == OpSub) ? ~b : b;
  assign cin   = (op == OpSub);
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {8'b0, cin};

  always_comb begin
    result    = a;
    flags_out = flags_in;
    zn_upd    = 1'b1;
    case (op)
      OpLda, OpLdx, OpLdy: result = b;
      OpAdd, OpSub: begin
        result           = sum[7:0];
        flags_out[FlagC] = sum[8];
        flags_out[FlagV] = (a[7] == b_eff[7]) && (sum[7] != a[7]);
      end
      OpAnd:   result = a & b;
      OpOr:    result = a | b;
      OpXor:   result = a ^ b;
      OpNot:   result = ~a;
      OpInc:   result = a + 8'd1;
      OpDec:   result = a - 8'd1;
      default: zn_upd = 1'b0;
    endcase
    if (zn_upd) begin
      flags_out[FlagZ] = (result == 8'h00);
      flags_out[FlagN] = result[7];
    end
  end

endmodule

// File: rtl/cpu8_core.sv
// cpu8_core: 8-bit accumulator CPU with a 16-bit address space.
// Every instruction is FETCH + EXEC (2 cycles); HLT parks the core until reset.
// Optional build macro CPU8_STORE_EN adds STA absolute (0x8D, 3 bytes, 4 cycles).
// Ports:
//   clk        in   1  clock, rising edge
//   reset      in   1  synchronous active-high reset
//   data_bus   in   8  memory read data for the current addr_bus
//   addr_bus   out 16  memory address
//   mem_read   out  1  core samples data_bus this cycle
//   mem_write  out  1  store cycle, data is acc_out
//   acc_out    out  8  accumulator
//   pc_out     out 16  program counter
//   flags_out  out  8  {4'b0, V, N, Z, C}
//   x_out      out  8  X register
//   y_out      out  8  Y register
//   halt       out  1  core is halted
module cpu8_core
  import cpu8_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_bus,
  output logic [15:0] addr_bus,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  acc_out,
  output logic [15:0] pc_out,
  output logic [7:0]  flags_out,
  output logic [7:0]  x_out,
  output logic [7:0]  y_out,
  output logic        halt
);

  cpu8_state_e state_q;
  logic [15:0] pc_q;
  logic [7:0]  acc_q;
  logic [7:0]  x_q;
  logic [7:0]  y_q;
  logic [3:0]  flags_q;
  logic [7:0]  ir_q;
`ifdef CPU8_STORE_EN
  logic [7:0]  adr_lo_q;
  logic [7:0]  adr_hi_q;
`endif

  logic [7:0]  alu_res;
  logic [3:0]  alu_flags;
  logic [15:0] pc_inc;
  logic [15:0] br_target;
  logic        br_taken;

  cpu8_alu u_alu (
    .op        (ir_q),
    .a         (acc_q),
    .b         (data_bus),
    .flags_in  (flags_q),
    .result    (alu_res),
    .flags_out (alu_flags)
  );

  assign pc_inc    = pc_q + 16'd1;
  // Offset is relative to the address following the operand byte.
  assign br_target = pc_inc + {{8{data_bus[7]}}, data_bus};

  always_comb begin
    case (ir_q)
      OpBeq:   br_taken = flags_q[FlagZ];
      OpBne:   br_taken = ~flags_q[FlagZ];
      OpBra:   br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  // Bus strobes decode from registered state; held low while reset is asserted.
  always_comb begin
    addr_bus  = pc_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (state_q)
      StFetch: mem_read = 1'b1;
      StExec:  mem_read = is_imm(ir_q);
`ifdef CPU8_STORE_EN
      StAdrl, StAdrh: mem_read = 1'b1;
      StStore: begin
        addr_bus  = {adr_hi_q, adr_lo_q};
        mem_write = 1'b1;
      end
`endif
      default: ;
    endcase
    if (reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      acc_q   <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      flags_q <= 4'h0;
      ir_q    <= OpNop;
`ifdef CPU8_STORE_EN
      adr_lo_q <= 8'h00;
      adr_hi_q <= 8'h00;
`endif
    end else begin
      case (state_q)
        StFetch: begin
          ir_q  <= data_bus;
          pc_q  <= pc_inc;
`ifdef CPU8_STORE_EN
          state_q <= (data_bus == OpSta) ? StAdrl : StExec;
`else
          state_q <= StExec;
`endif
        end
        StExec: begin
          state_q <= StFetch;
          if (is_branch(ir_q) && br_taken) begin
            pc_q <= br_target;
          end else if (is_imm(ir_q)) begin
            pc_q <= pc_inc;
          end
          if (writes_acc(ir_q)) acc_q <= alu_res;
          if (ir_q == OpLdx)    x_q   <= alu_res;
          if (ir_q == OpLdy)    y_q   <= alu_res;
          if (ir_q == OpHlt)    state_q <= StHalted;
          flags_q <= alu_flags;
        end
`ifdef CPU8_STORE_EN
        StAdrl: begin
          adr_lo_q <= data_bus;
          pc_q     <= pc_inc;
          state_q  <= StAdrh;
        end
        StAdrh: begin
          adr_hi_q <= data_bus;
          pc_q     <= pc_inc;
          state_q  <= StStore;
        end
        StStore: state_q <= StFetch;
`endif
        StHalted: state_q <= StHalted;
        default:  state_q <= StFetch;
      endcase
    end
  end

  assign acc_out   = acc_q;
  assign pc_out    = pc_q;
  assign flags_out = {4'b0000, flags_q};
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign halt      = (state_q == StHalted);

endmodule

// File: tb/tb_cpu8_core.sv
// tb_cpu8_core: directed self-checking bench for cpu8_core.
// Models a 256-byte combinational ROM at 0x0000-0x00FF; other addresses read 0.
// Build with CPU8_STORE_EN defined to exercise STA absolute.
module tb_cpu8_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_bus;
  logic [15:0] addr_bus;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  acc_out;
  logic [15:0] pc_out;
  logic [7:0]  flags_out;
  logic [7:0]  x_out;
  logic [7:0]  y_out;
  logic        halt;

  logic [7:0] rom [256];
  logic [7:0] prog [$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign data_bus = (addr_bus[15:8] == 8'h00) ? rom[addr_bus[7:0]] : 8'h00;

  cpu8_core #(.RESET_PC(16'h0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_bus  (data_bus),
    .addr_bus  (addr_bus),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .acc_out   (acc_out),
    .pc_out    (pc_out),
    .flags_out (flags_out),
    .x_out     (x_out),
    .y_out     (y_out),
    .halt      (halt)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load prog into ROM (rest zero) and hold reset for two edges.
  task automatic load_and_reset();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    // Program 1: loads, ALU chain, NOP, HLT at 0x14.
    prog = '{8'hA9, 8'h55, 8'hA2, 8'hAA, 8'hA0, 8'h33,
             8'h69, 8'h0A, 8'hE9, 8'h05, 8'h29, 8'hFF, 8'h09, 8'h0F, 8'h49, 8'hFF,
             8'hB6, 8'hE8, 8'hCA, 8'h00, 8'h02};
    load_and_reset();
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_acc", {8'h00, acc_out}, 16'h0000);
    chk("rst_xy", {x_out, y_out}, 16'h0000);
    chk("rst_flags", {8'h00, flags_out}, 16'h0000);
    chk("rst_halt", {15'd0, halt}, 16'h0000);
    chk("rst_mem_write", {15'd0, mem_write}, 16'h0000);

    tick(2);
    chk("lda_acc", {8'h00, acc_out}, 16'h0055);
    tick(2);
    chk("ldx_x", {8'h00, x_out}, 16'h00AA);
    chk("ldx_flags_n", {8'h00, flags_out}, 16'h0004);
    tick(2);
    chk("ldy_y", {8'h00, y_out}, 16'h0033);
    chk("ldy_flags", {8'h00, flags_out}, 16'h0000);
    chk("pc_after_6", pc_out, 16'h0006);
    chk("fetch_addr", addr_bus, 16'h0006);
    chk("fetch_rd", {15'd0, mem_read}, 16'h0001);
    tick(1);
    chk("exec_imm_addr", addr_bus, 16'h0007);
    chk("exec_imm_rd", {15'd0, mem_read}, 16'h0001);
    tick(1);
    chk("add_acc", {8'h00, acc_out}, 16'h005F);
    tick(2);
    chk("sub_acc", {8'h00, acc_out}, 16'h005A);
    chk("sub_flags_c", {8'h00, flags_out}, 16'h0001);
    tick(2);
    chk("and_acc", {8'h00, acc_out}, 16'h005A);
    tick(2);
    chk("or_acc", {8'h00, acc_out}, 16'h005F);
    tick(2);
    chk("xor_acc", {8'h00, acc_out}, 16'h00A0);
    chk("xor_flags_n", {8'h00, flags_out}, 16'h0005);
    tick(1);
    chk("exec_impl_rd", {15'd0, mem_read}, 16'h0000);
    chk("exec_impl_addr", addr_bus, 16'h0011);
    tick(1);
    chk("not_acc", {8'h00, acc_out}, 16'h005F);
    tick(2);
    chk("inc_acc", {8'h00, acc_out}, 16'h0060);
    tick(2);
    chk("dec_acc", {8'h00, acc_out}, 16'h005F);
    chk("pc_after_22", pc_out, 16'h0013);
    chk("dec_flags", {8'h00, flags_out}, 16'h0001);
    tick(2);
    chk("nop_pc", pc_out, 16'h0014);
    chk("nop_halt", {15'd0, halt}, 16'h0000);
    tick(2);
    chk("hlt_halt", {15'd0, halt}, 16'h0001);
    chk("hlt_pc", pc_out, 16'h0015);
    tick(3);
    chk("halted_pc", pc_out, 16'h0015);
    chk("halted_halt", {15'd0, halt}, 16'h0001);
    chk("halted_rd", {15'd0, mem_read}, 16'h0000);
    chk("halted_acc", {8'h00, acc_out}, 16'h005F);
    reset = 1'b1;
    tick(1);
    chk("rehalt_rst_pc", pc_out, 16'h0000);
    chk("rehalt_rst_halt", {15'd0, halt}, 16'h0000);
    chk("rehalt_rst_acc", {8'h00, acc_out}, 16'h0000);
    chk("rehalt_rst_rd", {15'd0, mem_read}, 16'h0000);
    reset = 1'b0;

    // Program 2: carry/overflow edges, SUB to zero, branches.
    prog = '{8'hA9, 8'hFF, 8'h69, 8'h01, 8'hA9, 8'h7F, 8'h69, 8'h01,
             8'hA9, 8'h05, 8'hE9, 8'h05, 8'hF0, 8'h02, 8'h02, 8'h02,
             8'hD0, 8'h05, 8'h80, 8'hFE};
    load_and_reset();
    tick(2);
    chk("ldff_flags", {8'h00, flags_out}, 16'h0004);
    tick(2);
    chk("addc_acc", {8'h00, acc_out}, 16'h0000);
    chk("addc_flags", {8'h00, flags_out}, 16'h0003);
    tick(2);
    chk("ld7f_flags", {8'h00, flags_out}, 16'h0001);
    tick(2);
    chk("addv_acc", {8'h00, acc_out}, 16'h0080);
    chk("addv_flags", {8'h00, flags_out}, 16'h000C);
    tick(2);
    chk("ld05_flags", {8'h00, flags_out}, 16'h0008);
    tick(2);
    chk("subz_acc", {8'h00, acc_out}, 16'h0000);
    chk("subz_flags", {8'h00, flags_out}, 16'h0003);
    tick(2);
    chk("beq_pc", pc_out, 16'h0010);
    chk("beq_flags", {8'h00, flags_out}, 16'h0003);
    tick(2);
    chk("bne_pc", pc_out, 16'h0012);
    tick(2);
    chk("bra_pc", pc_out, 16'h0012);
    chk("bra_addr", addr_bus, 16'h0012);
    tick(2);
    chk("bra_loop_pc", pc_out, 16'h0012);
    chk("bra_halt", {15'd0, halt}, 16'h0000);

    // Program 3: LDA #3C then opcode 0x8D with address 0x0200.
    prog = '{8'hA9, 8'h3C, 8'h8D, 8'h00, 8'h02};
    load_and_reset();
    tick(2);
    chk("sta_lda_acc", {8'h00, acc_out}, 16'h003C);
`ifdef CPU8_STORE_EN
    tick(2);
    chk("sta_adrh_wr", {15'd0, mem_write}, 16'h0000);
    tick(1);
    chk("sta_addr", addr_bus, 16'h0200);
    chk("sta_wr", {15'd0, mem_write}, 16'h0001);
    chk("sta_rd", {15'd0, mem_read}, 16'h0000);
    chk("sta_data", {8'h00, acc_out}, 16'h003C);
    tick(1);
    chk("sta_pc", pc_out, 16'h0005);
    chk("sta_wr_after", {15'd0, mem_write}, 16'h0000);
    chk("sta_flags", {8'h00, flags_out}, 16'h0000);
`else
    tick(1);
    chk("sta_nop_wr_a", {15'd0, mem_write}, 16'h0000);
    tick(1);
    chk("sta_nop_pc", pc_out, 16'h0003);
    chk("sta_nop_acc", {8'h00, acc_out}, 16'h003C);
    chk("sta_nop_wr_b", {15'd0, mem_write}, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
